// File: rtl/image_stream_pkg.sv
// rtl/image_stream_pkg.sv - shared defaults and state type for the image stream encoder/decoder pair
//
// Purpose: single source for frame geometry defaults and the stream FSM
// state encoding, so encoder and decoder agree on both.
// Contents:
//   DEFAULT_ROWS    rows (slices) per frame
//   DEFAULT_SLICE_W bits per row slice
//   DEFAULT_SEL_W   row-select width, clog2(DEFAULT_ROWS)
//   stream_state_e  IDLE (waiting for a frame) / SEND (streaming rows)
package image_stream_pkg;

  localparam int DEFAULT_ROWS    = 8;
  localparam int DEFAULT_SLICE_W = 8;
  localparam int DEFAULT_SEL_W   = $clog2(DEFAULT_ROWS);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stream_state_e;

endpackage

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enabled register without reset
//
// Purpose: WIDTH-bit register that loads d on a rising edge when en is high
// and holds otherwise. Contents are undefined until the first enabled load.
// Ports:
//   clk  in   rising-edge clock
//   en   in   load enable
//   d    in   [WIDTH-1:0] data to capture
//   q    out  [WIDTH-1:0] registered data
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/image_stream_encoder.sv
// rtl/image_stream_encoder.sv - serializes a captured frame into row slices with valid/ready flow control
//
// Purpose: accepts a whole frame in one handshake, then emits it one row per
// accepted beat, row 0 first, tagging each slice with its row index. A one-
// cycle done pulse follows the last accepted row.
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   image_i       in   [ROWS-1:0][SLICE_W-1:0] frame to serialize, row k = image_i[k]
//   load_valid_i  in   frame-offer strobe
//   load_ready_o  out  high while a new frame can be accepted (registered)
//   slice_o       out  [SLICE_W-1:0] current row data (registered)
//   sel_o         out  [SEL_W-1:0] index of the row on slice_o (registered)
//   valid_o       out  slice_o/sel_o hold a valid row (registered)
//   ready_i       in   downstream accepts the current row
//   en_o          out  valid_o & ready_i, decoder-side register enable (combinational)
//   done_o        out  one-cycle pulse after the last row is accepted (registered)
module image_stream_encoder
  import image_stream_pkg::*;
#(
  parameter int ROWS    = DEFAULT_ROWS,
  parameter int SLICE_W = DEFAULT_SLICE_W,
  parameter int SEL_W   = DEFAULT_SEL_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-1:0][SLICE_W-1:0]  image_i,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  output logic [SLICE_W-1:0]            slice_o,
  output logic [SEL_W-1:0]              sel_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          en_o,
  output logic                          done_o
);

  stream_state_e               r_state;
  logic [SEL_W-1:0]            r_idx;
  logic [SLICE_W-1:0]          r_slice;
  logic                        r_valid;
  logic                        r_load_ready;
  logic                        r_done;

  logic                        w_load_hs;
  logic                        w_row_hs;
  logic                        w_last_row;
  logic [SEL_W-1:0]            w_idx_next;
  logic [ROWS*SLICE_W-1:0]     w_frame_flat;
  logic [ROWS-1:0][SLICE_W-1:0] w_frame;

  // Load is only accepted in IDLE, which also makes the captured frame
  // immune to image_i changes while rows are streaming.
  assign w_load_hs  = (r_state == IDLE) && load_valid_i;
  assign w_row_hs   = r_valid && ready_i;
  assign w_last_row = (r_idx == SEL_W'(ROWS - 1));
  assign w_idx_next = r_idx + SEL_W'(1);

  flopenr #(
    .WIDTH (ROWS * SLICE_W)
  ) u_frame_reg (
    .clk (clk),
    .en  (w_load_hs),
    .d   (image_i),
    .q   (w_frame_flat)
  );

  assign w_frame = w_frame_flat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_slice      <= '0;
      r_valid      <= 1'b0;
      r_load_ready <= 1'b1;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load_hs) begin
            // Row 0 comes straight from image_i: the frame register is being
            // written on this same edge and cannot be read back yet.
            r_state      <= SEND;
            r_idx        <= '0;
            r_slice      <= image_i[0];
            r_valid      <= 1'b1;
            r_load_ready <= 1'b0;
          end
        end
        SEND: begin
          if (w_row_hs) begin
            if (w_last_row) begin
              // Index and slice are left on the last row; valid_o low marks
              // them stale, and the index never wraps within a frame.
              r_state      <= IDLE;
              r_valid      <= 1'b0;
              r_load_ready <= 1'b1;
              r_done       <= 1'b1;
            end else begin
              r_idx   <= w_idx_next;
              r_slice <= w_frame[w_idx_next];
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_valid      <= 1'b0;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready_o = r_load_ready;
  assign slice_o      = r_slice;
  assign sel_o        = r_idx;
  assign valid_o      = r_valid;
  assign done_o       = r_done;
  assign en_o         = r_valid & ready_i;

endmodule

// File: tb/tb_image_stream_encoder.sv
// tb/tb_image_stream_encoder.sv - self-checking bench for image_stream_encoder
module tb_image_stream_encoder;

  localparam int ROWS    = 8;
  localparam int SLICE_W = 8;
  localparam int SEL_W   = 3;

  typedef logic [ROWS-1:0][SLICE_W-1:0] img_t;

  logic                 clk = 1'b0;
  logic                 rst;
  img_t                 image_i;
  logic                 load_valid_i;
  logic                 load_ready_o;
  logic [SLICE_W-1:0]   slice_o;
  logic [SEL_W-1:0]     sel_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 en_o;
  logic                 done_o;

  image_stream_encoder #(
    .ROWS    (ROWS),
    .SLICE_W (SLICE_W),
    .SEL_W   (SEL_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .image_i      (image_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .slice_o      (slice_o),
    .sel_o        (sel_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .en_o         (en_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  // Reference decoder: writes the row addressed by sel_o whenever en_o fires.
  logic [SLICE_W-1:0] recon [ROWS];
  always @(posedge clk) begin
    if (en_o) recon[sel_o] <= slice_o;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       lv;
    logic       rdy;
    logic       use_b;
    logic       cd;
    logic       v;
    logic [2:0] sel;
    logic [7:0] slice;
    logic       done;
    logic       lr;
    logic       en;
  } vec_t;

  function automatic vec_t mk(logic lv, logic rdy, logic ub, logic cd, logic v,
                              logic [2:0] sel, logic [7:0] sl, logic dn, logic lr, logic en);
    vec_t t;
    t.lv = lv; t.rdy = rdy; t.use_b = ub; t.cd = cd; t.v = v;
    t.sel = sel; t.slice = sl; t.done = dn; t.lr = lr; t.en = en;
    return t;
  endfunction

  img_t img_a, img_b, img_r;
  vec_t vecs [15];

  // Loads img with ready_i high and checks every row plus the done pulse.
  task automatic run_frame(input img_t img, input string tag);
    @(negedge clk);
    load_valid_i = 1'b1; ready_i = 1'b1; image_i = img;
    for (int r = 0; r < ROWS; r++) begin
      @(negedge clk);
      load_valid_i = 1'b0;
      #1;
      chk($sformatf("%s.row%0d.valid", tag, r), valid_o, 1);
      chk($sformatf("%s.row%0d.sel", tag, r), sel_o, r);
      chk($sformatf("%s.row%0d.slice", tag, r), slice_o, img[r]);
    end
    @(negedge clk);
    #1;
    chk($sformatf("%s.done", tag), done_o, 1);
    chk($sformatf("%s.end_valid", tag), valid_o, 0);
  endtask

  initial begin
    for (int k = 0; k < ROWS; k++) begin
      img_a[k] = 8'(k);
      img_b[k] = 8'hA0 + 8'(k);
    end

    //        lv rdy B cd v sel slice dn lr en
    vecs[0]  = mk(0, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0);
    vecs[1]  = mk(1, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0);
    vecs[2]  = mk(0, 1, 0, 1, 1, 0, 8'h00, 0, 0, 1);
    vecs[3]  = mk(0, 1, 0, 1, 1, 1, 8'h01, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 1, 1, 2, 8'h02, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 1, 2, 8'h02, 0, 0, 0);
    vecs[6]  = mk(1, 0, 1, 1, 1, 2, 8'h02, 0, 0, 0);
    vecs[7]  = mk(1, 1, 1, 1, 1, 2, 8'h02, 0, 0, 1);
    vecs[8]  = mk(1, 1, 1, 1, 1, 3, 8'h03, 0, 0, 1);
    vecs[9]  = mk(0, 1, 1, 1, 1, 4, 8'h04, 0, 0, 1);
    vecs[10] = mk(0, 1, 0, 1, 1, 5, 8'h05, 0, 0, 1);
    vecs[11] = mk(0, 1, 0, 1, 1, 6, 8'h06, 0, 0, 1);
    vecs[12] = mk(0, 1, 0, 1, 1, 7, 8'h07, 0, 0, 1);
    vecs[13] = mk(0, 1, 0, 0, 0, 0, 8'h00, 1, 1, 0);
    vecs[14] = mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 1, 0);

    rst = 1'b1; load_valid_i = 1'b0; ready_i = 1'b0; image_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table: reset state, load latency, backpressure at row 2, load ignored in SEND.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      load_valid_i = vecs[i].lv;
      ready_i      = vecs[i].rdy;
      image_i      = vecs[i].use_b ? img_b : img_a;
      #1;
      chk($sformatf("vec%0d.valid", i), valid_o, vecs[i].v);
      chk($sformatf("vec%0d.done", i), done_o, vecs[i].done);
      chk($sformatf("vec%0d.load_ready", i), load_ready_o, vecs[i].lr);
      chk($sformatf("vec%0d.en", i), en_o, vecs[i].en);
      if (vecs[i].cd) begin
        chk($sformatf("vec%0d.sel", i), sel_o, vecs[i].sel);
        chk($sformatf("vec%0d.slice", i), slice_o, vecs[i].slice);
      end
    end

    // Single frame with ready high: rows on cycles 1..8, done on cycle 9,
    // frame B loaded in the done cycle appears the very next cycle.
    @(negedge clk);
    load_valid_i = 1'b1; ready_i = 1'b1; image_i = img_a;
    for (int c = 1; c <= ROWS; c++) begin
      @(negedge clk);
      load_valid_i = 1'b0;
      #1;
      chk($sformatf("b2b.a_row%0d.sel", c - 1), sel_o, c - 1);
      chk($sformatf("b2b.a_row%0d.slice", c - 1), slice_o, img_a[c-1]);
    end
    @(negedge clk);
    load_valid_i = 1'b1; image_i = img_b;
    #1;
    chk("b2b.a_done_cycle9", done_o, 1);
    chk("b2b.a_done_load_ready", load_ready_o, 1);
    @(negedge clk);
    load_valid_i = 1'b0; image_i = img_a;
    for (int r = 0; r < ROWS; r++) begin
      if (r != 0) @(negedge clk);
      #1;
      chk($sformatf("b2b.b_row%0d.valid", r), valid_o, 1);
      chk($sformatf("b2b.b_row%0d.sel", r), sel_o, r);
      chk($sformatf("b2b.b_row%0d.slice", r), slice_o, img_b[r]);
      chk($sformatf("b2b.b_row%0d.done", r), done_o, 0);
    end
    @(negedge clk);
    #1;
    chk("b2b.b_done", done_o, 1);
    @(negedge clk);
    #1;
    chk("b2b.done_one_cycle", done_o, 0);

    // Mid-frame reset at row 4, asserted together with a load offer.
    @(negedge clk);
    load_valid_i = 1'b1; ready_i = 1'b1; image_i = img_a;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      load_valid_i = 1'b0;
    end
    #1;
    chk("rst.sel_before", sel_o, 4);
    rst = 1'b1; load_valid_i = 1'b1;
    @(negedge clk);
    rst = 1'b0; load_valid_i = 1'b0;
    #1;
    chk("rst.valid", valid_o, 0);
    chk("rst.load_ready", load_ready_o, 1);
    chk("rst.done", done_o, 0);
    chk("rst.sel", sel_o, 0);
    chk("rst.slice", slice_o, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst.no_done%0d", c), done_o, 0);
    end
    run_frame(img_b, "after_rst");

    // Loopback through the reference decoder with random backpressure.
    for (int f = 0; f < 4; f++) begin
      logic got_done;
      for (int k = 0; k < ROWS; k++) img_r[k] = 8'($urandom);
      img_r[$urandom_range(0, ROWS - 1)] = 8'hFF;
      if (f == 0) img_r = '1;
      for (int k = 0; k < ROWS; k++) recon[k] = '0;
      @(negedge clk);
      load_valid_i = 1'b1; ready_i = 1'b0; image_i = img_r;
      got_done = 1'b0;
      for (int c = 0; c < 200 && !got_done; c++) begin
        @(negedge clk);
        load_valid_i = 1'b0;
        image_i = ~img_r;
        ready_i = 1'($urandom_range(0, 1));
        #1;
        if (done_o) got_done = 1'b1;
      end
      chk($sformatf("loop%0d.done_seen", f), got_done, 1);
      for (int k = 0; k < ROWS; k++)
        chk($sformatf("loop%0d.row%0d", f, k), recon[k], img_r[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/image_stream_encoder.md
IMAGE_STREAM_ENCODER -- requirements
Module: image_stream_encoder

Interface
REQ-001 Parameter ROWS, default 8: number of image rows (slices) per frame.
REQ-002 Parameter SLICE_W, default 8: bits per row slice.
REQ-003 Parameter SEL_W, default 3: row-select width, equal to clog2(ROWS).
REQ-004 Clocking SHALL be one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 image_i  input  [ROWS-1:0][SLICE_W-1:0]  frame to serialize; row k is image_i[k].
REQ-008 load_valid_i  input  1  frame-offer strobe.
REQ-009 load_ready_o  output  1  high when the block accepts a new frame.
REQ-010 slice_o  output  SLICE_W  current row data.
REQ-011 sel_o  output  SEL_W  index of the row on slice_o.
REQ-012 valid_o  output  1  slice_o/sel_o hold a valid row.
REQ-013 ready_i  input  1  downstream accepts the current row.
REQ-014 en_o  output  1  combinational valid_o & ready_i; drives the decoder-side register enable.
REQ-015 done_o  output  1  one-cycle pulse after the last row is accepted.

Function
REQ-016 FSM states SHALL be IDLE and SEND.
REQ-017 In IDLE: load_ready_o=1 and valid_o=0.
REQ-018 In SEND: load_ready_o=0 and valid_o=1.
REQ-019 A load handshake occurs on an edge where IDLE and load_valid_i=1.
REQ-020 On a load handshake, image_i SHALL be captured into an internal frame register, the row index SHALL be cleared to 0, and the FSM SHALL enter SEND.
REQ-021 The cycle after a load handshake: valid_o=1, sel_o=0, slice_o=captured row 0 (one-cycle load latency).
REQ-022 A row handshake occurs on an edge where valid_o=1 and ready_i=1.
REQ-023 While ready_i=0, slice_o, sel_o and valid_o SHALL hold stable.
REQ-024 On a row handshake with index < ROWS-1: index increments by 1, and slice_o/sel_o update on the next cycle.
REQ-025 On a row handshake with index = ROWS-1: the FSM returns to IDLE, valid_o falls next cycle, and done_o=1 for exactly that one cycle.
REQ-026 sel_o SHALL never exceed ROWS-1; the index SHALL NOT wrap within a frame.
REQ-027 load_valid_i and changes on image_i during SEND SHALL be ignored; the captured frame is immutable until the next load.
REQ-028 A new frame MAY load in the same cycle done_o is high (back-to-back: minimum one idle cycle between frames).
REQ-029 With ready_i held high, one frame SHALL take ROWS+1 cycles from load handshake to done_o.
REQ-030 slice_o, sel_o, valid_o, load_ready_o and done_o SHALL be registered outputs.
REQ-031 en_o SHALL be the only combinational output.

Reset
REQ-032 While rst=1 at an edge, the FSM SHALL enter IDLE and the index SHALL clear to 0.
REQ-033 Output reset values: slice_o=0, sel_o=0, valid_o=0, done_o=0, load_ready_o=1.
REQ-034 Reset mid-frame SHALL abort the frame with no done_o pulse.
REQ-035 The frame register need not be reset.
REQ-036 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-037 Shared package image_stream_pkg SHALL hold ROWS, SLICE_W and SEL_W defaults plus the state enum typedef (IDLE, SEND), shared with the decoder.
REQ-038 The frame capture register SHALL be one instance of the existing flopenr sub-module, width ROWS*SLICE_W, enable = load handshake.

Verification
REQ-039 Single frame, ready_i=1: load rows 0x00..0x07 -> sel_o 0..7 with slice_o 0x00..0x07 on consecutive cycles, done_o at cycle 9 after load.
REQ-040 Backpressure: ready_i=0 for 3 cycles while sel_o=2 -> slice_o/sel_o stay 2 for those cycles, en_o=0; all 8 rows still delivered in order.
REQ-041 Load ignored during SEND: assert load_valid_i with a new image mid-frame -> remaining rows come from the first frame, load_ready_o=0.
REQ-042 Back-to-back: load frame B in the done_o cycle of frame A -> B row 0 appears the next cycle, no row lost or duplicated.
REQ-043 Mid-frame reset at sel_o=4 -> next cycle valid_o=0, load_ready_o=1, no done_o; a fresh frame then streams from row 0.
REQ-044 Loopback: encoder driving image_stream_decoder through en_o, sel_o, slice_o -> reconstructed 8x8 image equals image_i for random patterns, including 0xFF rows.
